main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port `reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port `op`, input, 7 bits: opcode from the instruction register, stable from Decode onward.
REQ-005 The block SHALL have port `mem_ready`, input, 1 bit: the memory access in the current state completes this cycle.
REQ-006 The block SHALL have enable outputs, 1 bit each: `IRWrite`, `PCUpdate`, `RegWrite`, `MemWrite`, `Branch`, `AdrSrc`.
REQ-007 The block SHALL have select outputs, 2 bits each: `ALUSrcA`, `ALUSrcB`, `ResultSrc`, and `ALUOp` (ALUOp feeds the ALU decoder).
REQ-008 The block SHALL have port `illegal_op`, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-009 The block SHALL be a Moore FSM; every output is a pure function of state, except that IRWrite, PCUpdate (Fetch only) and MemWrite are ANDed with mem_ready.
REQ-010 State set SHALL be: Fetch, Decode, MemAdr, MemRead, MemWB, MemWrite, ExecuteR, ExecuteI, ALUWB, BEQ, JAL; unlisted outputs are 0.
REQ-011 Fetch SHALL drive AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10 and PCUpdate, and SHALL hold until mem_ready=1, then go to Decode.
REQ-012 Decode SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-013 Decode SHALL branch on op: 0000011/0100011 go to MemAdr, 0110011 to ExecuteR, 0010011 to ExecuteI, 1100011 to BEQ, 1101111 to JAL.
REQ-014 For any other op, Decode SHALL go to Fetch and pulse illegal_op for exactly that Decode cycle.
REQ-015 MemAdr SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MemRead if op=0000011, else to MemWrite.
REQ-016 MemRead SHALL drive AdrSrc=1, ResultSrc=00, hold until mem_ready=1, then go to MemWB.
REQ-017 MemWB SHALL drive ResultSrc=01 and RegWrite, then go to Fetch.
REQ-018 MemWrite SHALL drive AdrSrc=1, ResultSrc=00 and MemWrite (gated), hold until mem_ready=1, then go to Fetch.
REQ-019 ExecuteR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; ExecuteI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; both SHALL then go to ALUWB.
REQ-020 ALUWB SHALL drive ResultSrc=00 and RegWrite, then go to Fetch.
REQ-021 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00 and Branch, then go to Fetch.
REQ-022 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00 and PCUpdate, then go to ALUWB.
REQ-023 Cycle counts with mem_ready tied to 1 SHALL be: lw 5, sw 4, R/I-type 4, jal 4, beq 3, illegal 2.
REQ-024 Each wait state (Fetch, MemRead, MemWrite) SHALL hold indefinitely while mem_ready=0, with no write enable asserted and selects held.
REQ-025 op SHALL be ignored in every state except Decode and MemAdr.

Reset
REQ-026 Asserting reset_n=0 SHALL force state to Fetch immediately, including mid-instruction, and abort any pending access.
REQ-027 While reset_n=0, IRWrite, PCUpdate, RegWrite, MemWrite, Branch and illegal_op SHALL be 0; selects SHALL take their Fetch values.
REQ-028 The first Fetch after reset_n rises SHALL behave as a normal Fetch.

Configuration
REQ-029 With macro MAIN_FSM_JAL_EN defined, the JAL state and the 1101111 decode SHALL exist as specified.
REQ-030 Without MAIN_FSM_JAL_EN, op 1101111 SHALL be treated as illegal (REQ-014) and the JAL state SHALL not be synthesized.

Structure
REQ-031 A shared package SHALL hold the state enum, the opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL) and the ALUOp encodings (ADD=00, SUB=01, FUNCT=10).
REQ-032 The block SHALL be a single module: state register plus next-state and output always_comb blocks, with no sub-module.

Verification
REQ-033 Scenario lw: op=0000011, mem_ready=1 -> states Fetch, Decode, MemAdr, MemRead, MemWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
REQ-034 Scenario sw wait: op=0100011, mem_ready=0 for 3 cycles in MemWrite -> MemWrite=0 for those 3 cycles, 1 on the ready cycle, then Fetch.
REQ-035 Scenario beq/R-type: op=1100011 -> Branch=1 and ALUOp=01 in cycle 3; op=0110011 -> ALUOp=10 in cycle 3 and RegWrite in cycle 4.
REQ-036 Scenario illegal: op=1111111 -> illegal_op=1 for exactly the Decode cycle, then Fetch; no write enable asserted.
REQ-037 Scenario reset: reset_n=0 asserted mid-MemRead -> same-cycle state Fetch, all enables 0; after release, IRWrite=1 on the first mem_ready=1.
REQ-038 Scenario JAL: op=1101111, run under both macro settings -> with MAIN_FSM_JAL_EN, PCUpdate=1 in JAL, then RegWrite in ALUWB; without it, illegal_op=1.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding,
// decoded opcodes and ALUOp encodings, plus an opcode-support helper.
// Optional feature macro: MAIN_FSM_JAL_EN (enables jal decode/state).
package main_fsm_pkg;

  // State encoding, kept as plain constants for legacy compatibility.
  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_JAL      = 4'd10;

  // Opcodes recognised by the decoder.
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALUOp encodings consumed by the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True when the opcode has a decode path in this build.
  function automatic logic op_supported(input logic [6:0] opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ: ok = 1'b1;
`ifdef MAIN_FSM_JAL_EN
      OP_JAL: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM (Moore); one state per cycle, Fetch/MemRead/MemWrite
// wait on mem_ready with enables held low until it rises; jal path only when
// MAIN_FSM_JAL_EN is defined, otherwise 1101111 decodes as illegal.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       illegal_op
);

  state_t state;
  state_t state_nxt;

  // State register; reset aborts any instruction and returns to Fetch at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: op is only looked at in Decode and MemAdr.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTER;
          OP_ITYPE:     state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
`ifdef MAIN_FSM_JAL_EN
          OP_JAL:       state_nxt = S_JAL;
`endif
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
`ifdef MAIN_FSM_JAL_EN
      S_JAL:      state_nxt = S_ALUWB;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Outputs: decoded from state; memory-side enables also need mem_ready, and the
  // Fetch enables are masked by reset_n since state sits in Fetch during reset.
  always_comb begin
    IRWrite    = 1'b0;
    PCUpdate   = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUOp      = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = mem_ready & reset_n;
        PCUpdate  = mem_ready & reset_n;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        illegal_op = ~op_supported(op);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = ALUOP_SUB;
        Branch  = 1'b1;
      end
`ifdef MAIN_FSM_JAL_EN
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
`endif
      default: begin
        IRWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Randomised bench for main_fsm: each instruction is expanded into its expected
// step sequence, mem_ready is randomised per cycle, and every cycle's outputs are
// compared with the step's expected values. Honours MAIN_FSM_JAL_EN.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       IRWrite, PCUpdate, RegWrite, MemWrite, Branch, AdrSrc, illegal_op;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCUpdate(PCUpdate), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Branch(Branch), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .illegal_op(illegal_op)
  );

  // {illegal_op, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, AdrSrc,
  //  ALUSrcA, ALUSrcB, ResultSrc, ALUOp}
  wire [16:0] dut_vec = {illegal_op, IRWrite, PCUpdate, RegWrite, MemWrite, Branch,
                         AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp};

  typedef enum {K_FETCH, K_DECODE, K_DECODE_ILL, K_MEMADR, K_MEMREAD, K_MEMWB,
                K_MEMWRITE, K_EXECR, K_EXECI, K_ALUWB, K_BEQ, K_JAL} step_e;

  step_e seq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs of one step, taken from the per-state output table.
  function automatic logic [16:0] expect_of(step_e s, logic mr);
    logic ill, irw, pcu, rw, mw, br, adr;
    logic [1:0] a, b, r, o;
    {ill, irw, pcu, rw, mw, br, adr} = 7'b0;
    a = 2'b00; b = 2'b00; r = 2'b00; o = 2'b00;
    case (s)
      K_FETCH:      begin b = 2'b10; r = 2'b10; irw = mr; pcu = mr; end
      K_DECODE:     begin a = 2'b01; b = 2'b01; end
      K_DECODE_ILL: begin a = 2'b01; b = 2'b01; ill = 1'b1; end
      K_MEMADR:     begin a = 2'b10; b = 2'b01; end
      K_MEMREAD:    begin adr = 1'b1; end
      K_MEMWB:      begin r = 2'b01; rw = 1'b1; end
      K_MEMWRITE:   begin adr = 1'b1; mw = mr; end
      K_EXECR:      begin a = 2'b10; o = 2'b10; end
      K_EXECI:      begin a = 2'b10; b = 2'b01; o = 2'b10; end
      K_ALUWB:      begin rw = 1'b1; end
      K_BEQ:        begin a = 2'b10; o = 2'b01; br = 1'b1; end
      K_JAL:        begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
      default:      begin end
    endcase
    return {ill, irw, pcu, rw, mw, br, adr, a, b, r, o};
  endfunction

  function automatic logic is_wait(step_e s);
    return (s == K_FETCH) || (s == K_MEMREAD) || (s == K_MEMWRITE);
  endfunction

  // One clock cycle: drive inputs just after the edge, compare on the falling edge.
  // op carries the instruction only where it matters; elsewhere it is noise.
  task automatic do_cycle(input step_e s, input logic [6:0] iop, input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    if (s == K_DECODE || s == K_DECODE_ILL || s == K_MEMADR) op = iop;
    else op = 7'($urandom);
    @(negedge clk);
    chk(s.name(), {15'd0, dut_vec}, {15'd0, expect_of(s, mr)});
  endtask

  task automatic build_seq(input logic [6:0] iop);
    seq.delete();
    seq.push_back(K_FETCH);
    case (iop)
      7'b0000011: begin seq.push_back(K_DECODE); seq.push_back(K_MEMADR);
                        seq.push_back(K_MEMREAD); seq.push_back(K_MEMWB); end
      7'b0100011: begin seq.push_back(K_DECODE); seq.push_back(K_MEMADR);
                        seq.push_back(K_MEMWRITE); end
      7'b0110011: begin seq.push_back(K_DECODE); seq.push_back(K_EXECR);
                        seq.push_back(K_ALUWB); end
      7'b0010011: begin seq.push_back(K_DECODE); seq.push_back(K_EXECI);
                        seq.push_back(K_ALUWB); end
      7'b1100011: begin seq.push_back(K_DECODE); seq.push_back(K_BEQ); end
`ifdef MAIN_FSM_JAL_EN
      7'b1101111: begin seq.push_back(K_DECODE); seq.push_back(K_JAL);
                        seq.push_back(K_ALUWB); end
`endif
      default:    seq.push_back(K_DECODE_ILL);
    endcase
  endtask

  // Runs a whole instruction; wait states see at most three stalled cycles.
  task automatic run_instr(input logic [6:0] iop, input int ready_pct);
    build_seq(iop);
    foreach (seq[i]) begin
      int stalls;
      logic mr;
      logic done;
      stalls = 0;
      done = 1'b0;
      while (!done) begin
        mr = (stalls >= 3) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
        do_cycle(seq[i], iop, mr);
        if (is_wait(seq[i]) && !mr) stalls++;
        else done = 1'b1;
      end
    end
  endtask

  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1100011, 7'b1101111};
  localparam logic [16:0] RST_VEC = {7'b0, 2'b00, 2'b10, 2'b10, 2'b00};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    op        = 7'b0000011;
    #3;
    chk("reset_outputs", {15'd0, dut_vec}, {15'd0, RST_VEC});
    @(posedge clk); @(posedge clk);
    #1;
    chk("reset_held", {15'd0, dut_vec}, {15'd0, RST_VEC});
    mem_ready = 1'b0;
    reset_n   = 1'b1;

    // Each opcode class once with memory always ready, then the sw stall case.
    foreach (legal_ops[k]) run_instr(legal_ops[k], 100);
    run_instr(7'b1111111, 100);
    run_instr(7'b0100011, 0);

    // Random instruction mix with random memory latency.
    for (int n = 0; n < 300; n++) begin
      int pick;
      logic [6:0] iop;
      pick = int'($urandom_range(0, 7));
      iop = (pick < 6) ? legal_ops[pick] : 7'($urandom);
      run_instr(iop, 60);
    end

    // Reset in the middle of a stalled MemRead.
    do_cycle(K_FETCH, 7'b0000011, 1'b1);
    do_cycle(K_DECODE, 7'b0000011, 1'b1);
    do_cycle(K_MEMADR, 7'b0000011, 1'b1);
    do_cycle(K_MEMREAD, 7'b0000011, 1'b0);
    #2;
    mem_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("reset_mid_memread", {15'd0, dut_vec}, {15'd0, RST_VEC});
    @(posedge clk);
    #1;
    chk("reset_mid_hold", {15'd0, dut_vec}, {15'd0, RST_VEC});
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    #1;
    chk("fetch_after_reset_wait", {31'd0, IRWrite}, 32'd0);
    run_instr(7'b0000011, 100);
    run_instr(7'b1101111, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
